// File: rtl/seg_frame_decoder.sv
// rtl/seg_frame_decoder.sv - debounced seven-segment bus read-back into 16-bit frames
// Samples the multiplexed segment bus, accepts stable digits, assembles 4-digit frames.
module seg_frame_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_in,
  input  logic [3:0]  digit_en_n,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] out_value,
  output logic [3:0]  out_dp,
  output logic        out_err,
  output logic        overrun
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);

  logic [7:0]    samp_seg;
  logic [3:0]    samp_en;
  logic [7:0]    prev_seg;
  logic [3:0]    prev_en;
  logic [CW-1:0] stab_cnt;
  logic [CW-1:0] cnt_next;
  logic          accepted;
  logic          accepted_next;
  logic          qualified;
  logic          same;
  logic          accept;
  logic [1:0]    idx;

  logic [4:0]    decoded;
  logic          dec_err;
  logic [3:0]    dec_nib;
  logic          dec_dp;

  logic [3:0]    slot_nib [4];
  logic [3:0]    slot_dp;
  logic [3:0]    slot_err;
  logic [3:0]    mask;
  logic [3:0]    mask_next;
  logic [3:0]    err_next;
  logic          frame_full;
  logic          load;

  // Active-high gfedcba pattern to {error, nibble}; unknown patterns decode as 0 with error.
  function automatic logic [4:0] seg_decode(input logic [6:0] code);
    logic [4:0] r;
    case (code)
      7'h3F: r = 5'h00;
      7'h06: r = 5'h01;
      7'h5B: r = 5'h02;
      7'h4F: r = 5'h03;
      7'h66: r = 5'h04;
      7'h6D: r = 5'h05;
      7'h7D: r = 5'h06;
      7'h07: r = 5'h07;
      7'h7F: r = 5'h08;
      7'h6F: r = 5'h09;
      7'h77: r = 5'h0A;
      7'h7C: r = 5'h0B;
      7'h39: r = 5'h0C;
      7'h5E: r = 5'h0D;
      7'h79: r = 5'h0E;
      7'h71: r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  always_comb begin
    qualified = 1'b1;
    idx       = 2'd0;
    case (samp_en)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: qualified = 1'b0;
    endcase
  end

  assign same = (samp_seg == prev_seg) && (samp_en == prev_en);

  // Count includes the current sample, so a new pattern starts at 1.
  always_comb begin
    cnt_next = '0;
    if (qualified) begin
      if (!same) begin
        cnt_next = CW'(1);
      end else if (stab_cnt == STABLE_MAX) begin
        cnt_next = STABLE_MAX;
      end else begin
        cnt_next = stab_cnt + CW'(1);
      end
    end
  end

  // The old accept flag only blocks when the sample is unchanged.
  assign accept        = qualified && (cnt_next == STABLE_MAX) && !(accepted && same);
  assign accepted_next = accept || (accepted && same && qualified);

  assign decoded = seg_decode(~samp_seg[6:0]);
  assign dec_err = decoded[4];
  assign dec_nib = decoded[3:0];
  assign dec_dp  = ~samp_seg[7];

  assign frame_full = (mask == 4'b1111);
  assign load       = frame_full && (!out_valid || out_ready);

  // Completion clears first, so a same-cycle accept lands in the next frame.
  always_comb begin
    mask_next = frame_full ? 4'b0000 : mask;
    err_next  = frame_full ? 4'b0000 : slot_err;
    if (accept) begin
      mask_next[idx] = 1'b1;
      err_next[idx]  = dec_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_seg  <= '0;
      samp_en   <= '0;
      prev_seg  <= '0;
      prev_en   <= '0;
      stab_cnt  <= '0;
      accepted  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        slot_nib[i] <= '0;
      end
      slot_dp   <= '0;
      slot_err  <= '0;
      mask      <= '0;
      out_valid <= 1'b0;
      out_value <= '0;
      out_dp    <= '0;
      out_err   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      samp_seg <= seg_in;
      samp_en  <= digit_en_n;
      prev_seg <= samp_seg;
      prev_en  <= samp_en;
      stab_cnt <= cnt_next;
      accepted <= accepted_next;

      if (accept) begin
        slot_nib[idx] <= dec_nib;
        slot_dp[idx]  <= dec_dp;
      end
      slot_err <= err_next;
      mask     <= mask_next;

      if (load) begin
        out_valid <= 1'b1;
        out_value <= {slot_nib[3], slot_nib[2], slot_nib[1], slot_nib[0]};
        out_dp    <= slot_dp;
        out_err   <= |slot_err;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (frame_full && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: doc/seg_frame_decoder.md
# seg_frame_decoder

Receive-side decoder for the active-low seven-segment bus. It samples a multiplexed segment bus (segments plus one-hot active-low digit enables) and debounces each digit pattern. Each pattern is decoded back to a hex nibble, and four digits are assembled into a 16-bit frame that is handed out over a valid/ready handshake. It sits on board-level self-check and loopback paths, where display drive output is read back and compared against the value that produced it.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required to accept a digit (≥1)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- seg_in  in  8  segment bus, active-low (0 = lit); bit0..bit6 = a..g, bit7 = dp
- digit_en_n  in  4  digit select, active-low, one-hot (bit i low = digit i driven)
- out_ready  in  1  consumer accepts frame
- out_valid  out  1  frame available
- out_value  out  16  {digit3, digit2, digit1, digit0} nibbles
- out_dp  out  4  dp lit per digit (1 = lit)
- out_err  out  1  at least one digit in the frame had an undecodable pattern
- overrun  out  1  sticky: a complete frame was dropped due to backpressure

## Operation
- Stage 1: seg_in and digit_en_n are registered every cycle (sample regs).
- Stability: the sample is *qualified* when digit_en_n has exactly one bit low.
  - Counter increments while the qualified sample equals the previous sample.
  - Counter clears on any change or on an unqualified sample.
  - A digit is accepted once per stable interval, on the cycle its count reaches STABLE_CYCLES.
  - An accept flag blocks re-acceptance until the sample changes.
- Decode: invert seg[6:0] to active-high gfedcba. Match against the table:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71.
  - On no match, nibble = 0 and the digit's error bit is set.
  - dp = ~seg[7].
- Accept into slot i:
  - Write nibble, dp and error bit into slot i.
  - Set mask[i].
  - Re-accepting a digit already in the mask overwrites it; the latest value wins.
- Frame completion (mask == 4'b1111), evaluated each cycle:
  - If !out_valid or out_ready: load the outputs from the slots. out_err = OR of the slot error bits. Set out_valid = 1. Clear mask and error bits.
  - Otherwise: set overrun = 1, discard the frame and clear the mask. The held output is untouched.
- Handshake: a transfer occurs on a cycle with out_valid && out_ready.
  - out_valid falls next cycle unless a new frame loads on that same cycle, in which case it stays 1 with the new data.
  - out_value, out_dp and out_err are stable while out_valid && !out_ready.
- Collection continues while a frame is held.

## Timing
- Reset values: out_valid = 0, out_value = 0, out_dp = 0, out_err = 0, overrun = 0. Mask, slots, counter, accept flag and sample regs are all cleared.
- overrun is cleared only by rst.
- Digit acceptance: a pattern driven constant from edge k is written to its slot at edge k+STABLE_CYCLES.
- Frame output: if the 4th digit is accepted at edge n, out_valid = 1 after edge n+1, provided no backpressure.
- Minimum digit dwell is STABLE_CYCLES cycles; any shorter pattern is ignored (glitch rejection).
- Reset mid-frame: the partial frame is lost. Collection restarts from an empty mask in the cycle after rst deasserts.
- Simultaneous accept and completion: an accept on the cycle the mask is found full goes into the next frame's mask, after the clear.

## Test plan
- STABLE_CYCLES=4, out_ready=1. Hold each (digit_en_n, seg_in) for 6 cycles: (1110,C0), (1101,F9), (1011,A4), (0111,B0). Required: one out_valid pulse, out_value=0x3210, out_dp=0, out_err=0.
- Glitch rejection: (1101,F9) held 3 cycles between otherwise valid digits. Required: no frame until digit 1 is held ≥4 cycles.
- Invalid pattern: digit 2 driven 0xFF (blank), others as in scenario 1. Required: out_value=0x3010, out_err=1.
- DP: digit 0 driven 0x40 ('0' with dp lit). Required: out_dp=4'b0001.
- Backpressure: out_ready=0 while two complete frames arrive. Required:
  - First frame stays held and stable.
  - overrun=1 after the second frame completes.
  - Raising out_ready transfers the first frame and out_valid drops next cycle.
- Qualification and reset: digit_en_n=1100 for 10 cycles produces no accept. rst asserted after 2 digits are accepted, then all 4 digits driven: exactly one frame is produced, with all outputs at reset values before it.
